debug_output_fifo: RTL and testbench

Parametrised successor to the single-register debug output port. It accepts debug words from the CPU over a Wishbone slave interface and buffers them in a first-word-fall-through FIFO. It drains them to a downstream consumer (UART bridge, logic analyser tap) over a valid/ready handshake, and exposes level and overflow status for polling firmware.

---
 rtl/debug_output_fifo_if.sv | 26 ++
 rtl/debug_output_fifo.sv | 113 +++++++++++
 tb/tb_debug_output_fifo.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_output_fifo_if.sv
// Bus and drain signal bundle for debug_output_fifo: Wishbone slave side plus valid/ready drain.
// The DUT takes the slave modport; a bus master / consumer model takes the master modport.
interface debug_output_fifo_if #(
   parameter int unsigned DW = 8
);
   logic          i_wb_adr;
   logic [31:0]   i_wb_dat;
   logic          i_wb_we;
   logic          i_wb_cyc;
   logic          i_wb_stb;
   logic          o_wb_ack;
   logic [31:0]   o_wb_rdt;
   logic          o_debug_valid;
   logic [DW-1:0] o_debug_data;
   logic          i_debug_ready;

   modport slave (
      input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb, i_debug_ready,
      output o_wb_ack, o_wb_rdt, o_debug_valid, o_debug_data
   );

   modport master (
      output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb, i_debug_ready,
      input  o_wb_ack, o_wb_rdt, o_debug_valid, o_debug_data
   );
endinterface

// File: rtl/debug_output_fifo.sv
// Wishbone-fed first-word-fall-through debug FIFO with valid/ready drain and STATUS register.
// Define DEBUG_OUTPUT_FIFO_OVERWRITE_EN to drop the oldest entry (instead of the new word) when full.
module debug_output_fifo #(
   parameter  int unsigned DW    = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input logic                i_wb_clk,
   input logic                i_rst_n,
   debug_output_fifo_if.slave bus
);
   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam logic [AW-1:0] PtrOne  = AW'(1);
   localparam logic [CW-1:0] LvlOne  = CW'(1);
   localparam logic [CW-1:0] LvlFull = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] level_q, level_d;
   logic          ovf_q;
   logic [7:0]    drop_q;
   logic          ack_q;
   logic [31:0]   rdt_q;

   logic          req, push, pop, full, empty, ovf_evt, clr, wr_en, adv_rd;
   logic [DW-1:0] head;
   logic [31:0]   status, rd_val;

   always_comb begin
      empty   = (level_q == '0);
      full    = (level_q == LvlFull);
      req     = bus.i_wb_cyc & bus.i_wb_stb & ~ack_q;
      push    = req & bus.i_wb_we & ~bus.i_wb_adr;
      pop     = ~empty & bus.i_debug_ready;
      ovf_evt = push & full & ~pop;
      clr     = req & bus.i_wb_we & bus.i_wb_adr & bus.i_wb_dat[18];
`ifdef DEBUG_OUTPUT_FIFO_OVERWRITE_EN
      wr_en   = push;
      adv_rd  = pop | ovf_evt;
`else
      wr_en   = push & ~ovf_evt;
      adv_rd  = pop;
`endif
      level_d = level_q;
      if (wr_en && !adv_rd) begin
         level_d = level_q + LvlOne;
      end else if (adv_rd && !wr_en) begin
         level_d = level_q - LvlOne;
      end

      // Memory is not reset, so mask the head while empty.
      head = empty ? '0 : mem[rd_ptr_q];

      status         = '0;
      status[CW-1:0] = level_q;
      status[16]     = empty;
      status[17]     = full;
      status[18]     = ovf_q;
      status[31:24]  = drop_q;

      rd_val = '0;
      if (!bus.i_wb_we) begin
         if (bus.i_wb_adr) begin
            rd_val = status;
         end else begin
            rd_val[DW-1:0] = head;
         end
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.i_wb_dat[DW-1:0];
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
         ack_q    <= 1'b0;
         rdt_q    <= '0;
      end else begin
         ack_q   <= req;
         level_q <= level_d;
         if (req) begin
            rdt_q <= rd_val;
         end
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (adv_rd) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         // An overflow in the same cycle as a clear leaves a fresh count of one.
         if (ovf_evt) begin
            ovf_q  <= 1'b1;
            drop_q <= clr ? 8'd1 : ((drop_q == 8'hff) ? drop_q : drop_q + 8'd1);
         end else if (clr) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
         end
      end
   end

   assign bus.o_wb_ack      = ack_q;
   assign bus.o_wb_rdt      = rdt_q;
   assign bus.o_debug_valid = ~empty;
   assign bus.o_debug_data  = head;
endmodule

// File: tb/tb_debug_output_fifo.sv
// Self-checking bench for debug_output_fifo: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_debug_output_fifo;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   debug_output_fifo_if #(.DW(DW)) bus ();

   debug_output_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .i_wb_clk (clk),
      .i_rst_n  (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0]  q[$];
   bit          m_ovf;
   int          m_drop;
   bit          m_ack;
   bit          m_rd;
   logic [31:0] m_rdt;

   typedef struct {
      bit          cyc;
      bit          we;
      bit          adr;
      logic [31:0] dat;
      bit          rdy;
      bit          exp_ack;
      bit          chk_rdt;
      logic [31:0] exp_rdt;
      bit          exp_valid;
      logic [7:0]  exp_data;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s        = '0;
      s[15:0]  = 16'(q.size());
      s[16]    = (q.size() == 0);
      s[17]    = (q.size() == DEPTH);
      s[18]    = m_ovf;
      s[31:24] = 8'(m_drop);
      return s;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_ack  = 1'b0;
      m_rd   = 1'b0;
      m_rdt  = '0;
   endtask

   task automatic drive_idle();
      bus.i_wb_cyc      = 1'b0;
      bus.i_wb_stb      = 1'b0;
      bus.i_wb_we       = 1'b0;
      bus.i_wb_adr      = 1'b0;
      bus.i_wb_dat      = '0;
      bus.i_debug_ready = 1'b0;
   endtask

   task automatic check_outputs();
      check("ack", 32'(bus.o_wb_ack), 32'(m_ack));
      if (m_ack && m_rd) check("rdt", bus.o_wb_rdt, m_rdt);
      check("valid", 32'(bus.o_debug_valid), 32'(q.size() != 0));
      check("data", 32'(bus.o_debug_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
   endtask

   // One clock: drive inputs, advance the model by the same rules, then compare after the edge.
   task automatic tick(input bit cyc, input bit stb, input bit we, input bit adr,
                       input logic [31:0] dat, input bit rdy);
      bit          req, push, pop, full, evt, clr;
      logic [31:0] rd_val;
      bus.i_wb_cyc      = cyc;
      bus.i_wb_stb      = stb;
      bus.i_wb_we       = we;
      bus.i_wb_adr      = adr;
      bus.i_wb_dat      = dat;
      bus.i_debug_ready = rdy;
      req    = cyc && stb && !m_ack;
      push   = req && we && !adr;
      pop    = (q.size() != 0) && rdy;
      full   = (q.size() == DEPTH);
      evt    = push && full && !pop;
      clr    = req && we && adr && dat[18];
      rd_val = adr ? m_status() : ((q.size() != 0) ? 32'(q[0]) : 32'h0);
      if (pop) void'(q.pop_front());
      if (push) begin
         if (!evt) q.push_back(dat[7:0]);
`ifdef DEBUG_OUTPUT_FIFO_OVERWRITE_EN
         else begin
            void'(q.pop_front());
            q.push_back(dat[7:0]);
         end
`endif
      end
      if (evt) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      m_ack = req;
      if (req) begin
         m_rd  = !we;
         m_rdt = rd_val;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input bit rdy);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, rdy);
   endtask

   task automatic bus_write(input bit adr, input logic [31:0] dat, input bit rdy);
      tick(1'b1, 1'b1, 1'b1, adr, dat, rdy);
      idle(rdy);
   endtask

   task automatic bus_read(input bit adr, output logic [31:0] rdt);
      tick(1'b1, 1'b1, 1'b0, adr, 32'h0, 1'b0);
      rdt = bus.o_wb_rdt;
      idle(1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain_check(input int n, input logic [7:0] first, input string name);
      for (int i = 0; i < n; i++) begin
         check(name, 32'(bus.o_debug_data), 32'(first + 8'(i)));
         idle(1'b1);
      end
   endtask

   initial begin
      vec_t        tbl[12];
      logic [31:0] st;
      logic [7:0]  last;
      logic [7:0]  first_exp;

      drive_idle();
      model_reset();
      @(posedge clk);
      #1;
      check("rst_ack", 32'(bus.o_wb_ack), 32'h0);
      check("rst_rdt", bus.o_wb_rdt, 32'h0);
      check("rst_valid", 32'(bus.o_debug_valid), 32'h0);
      check("rst_data", 32'(bus.o_debug_data), 32'h0);
      do_reset();

      // Directed table: cyc, we, adr, dat, rdy | ack, chk_rdt, rdt, valid, data
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'hA5, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 8'hA5};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 8'hA5};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 8'hA5};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 8'hA5};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_00A5, 1'b1, 8'hA5};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      for (int i = 0; i < 12; i++) begin
         tick(tbl[i].cyc, tbl[i].cyc, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].rdy);
         check("tbl_ack", 32'(bus.o_wb_ack), 32'(tbl[i].exp_ack));
         if (tbl[i].chk_rdt) check("tbl_rdt", bus.o_wb_rdt, tbl[i].exp_rdt);
         check("tbl_valid", 32'(bus.o_debug_valid), 32'(tbl[i].exp_valid));
         check("tbl_data", 32'(bus.o_debug_data), 32'(tbl[i].exp_data));
      end

      // 17 writes into a 16-deep FIFO with the consumer stalled
      do_reset();
      for (int i = 0; i <= 16; i++) bus_write(1'b0, 32'(i), 1'b0);
      bus_read(1'b1, st);
      check("ovf_level", 32'(st[4:0]), 32'd16);
      check("ovf_full", 32'(st[17]), 32'h1);
      check("ovf_flag", 32'(st[18]), 32'h1);
      check("ovf_drop", 32'(st[31:24]), 32'h1);
`ifdef DEBUG_OUTPUT_FIFO_OVERWRITE_EN
      first_exp = 8'h01;
`else
      first_exp = 8'h00;
`endif
      drain_check(16, first_exp, "ovf_drain");
      check("ovf_empty", 32'(bus.o_debug_valid), 32'h0);

      // Full FIFO with a simultaneous pop: no overflow, 0x77 comes out last
      bus_write(1'b1, 32'h0004_0000, 1'b0);
      for (int i = 0; i < 16; i++) bus_write(1'b0, 32'h20 + 32'(i), 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 1'b1);
      idle(1'b0);
      bus_read(1'b1, st);
      check("pp_level", 32'(st[4:0]), 32'd16);
      check("pp_ovf", 32'(st[18]), 32'h0);
      drain_check(15, 8'h21, "pp_drain");
      last = bus.o_debug_data;
      idle(1'b1);
      check("pp_last", 32'(last), 32'h77);

      // Drop counter saturation and STATUS clear
      for (int i = 0; i < 16; i++) bus_write(1'b0, 32'h40 + 32'(i), 1'b0);
      for (int i = 0; i < 300; i++) bus_write(1'b0, 32'(i), 1'b0);
      bus_read(1'b1, st);
      check("sat_drop", 32'(st[31:24]), 32'd255);
      check("sat_ovf", 32'(st[18]), 32'h1);
      bus_write(1'b1, 32'h0004_0000, 1'b0);
      bus_read(1'b1, st);
      check("clr_drop", 32'(st[31:24]), 32'h0);
      check("clr_ovf", 32'(st[18]), 32'h0);
      check("clr_level", 32'(st[4:0]), 32'd16);
`ifdef DEBUG_OUTPUT_FIFO_OVERWRITE_EN
      first_exp = 8'h1C;
`else
      first_exp = 8'h40;
`endif
      drain_check(16, first_exp, "clr_drain");

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] d;
         d     = $urandom;
         d[18] = ($urandom_range(0, 7) == 0);
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 5) == 0, d, $urandom_range(0, 2) == 0);
      end

      // Asynchronous reset mid-drain with level 5
      do_reset();
      for (int i = 0; i < 6; i++) bus_write(1'b0, 32'h60 + 32'(i), 1'b0);
      idle(1'b1);
      bus_read(1'b1, st);
      check("pre_rst_level", 32'(st[4:0]), 32'd5);
      bus.i_debug_ready = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_ack", 32'(bus.o_wb_ack), 32'h0);
      check("arst_valid", 32'(bus.o_debug_valid), 32'h0);
      check("arst_data", 32'(bus.o_debug_data), 32'h0);
      drive_idle();
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus_read(1'b1, st);
      check("post_rst_status", st, 32'h0001_0000);
      bus_write(1'b0, 32'h5A, 1'b0);
      check("post_rst_data", 32'(bus.o_debug_data), 32'h5A);
      idle(1'b1);
      check("post_rst_drain", 32'(bus.o_debug_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
